serial_word_rx: RTL and testbench

Serial-to-parallel receive stage that sits directly downstream of the universal shift register running in one of its serial-output modes. It samples the serial bit (register output bit 0) on each enable strobe and assembles DW-bit words, MSB-first or LSB-first. Completed words go into a 2-entry output buffer with a valid/ready handshake. A sticky flag records words dropped because the buffer was full.

---
 rtl/serial_word_rx.sv | 148 ++++++++++++++
 tb/tb_serial_word_rx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_word_rx.sv
// rtl/serial_word_rx.sv - serial-to-parallel word receiver with 2-entry output FIFO
module serial_word_rx #(
  parameter int DW = 4,
  localparam int CW = $clog2(DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enb,
  input  logic          ser_in,
  input  logic          msb_first,
  input  logic          clr,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic [1:0]    fill,
  output logic [CW-1:0] bit_cnt,
  output logic          overflow
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          ord_q, ord_d;
  logic [DW-1:0] ent0_q, ent0_d;
  logic [DW-1:0] ent1_q, ent1_d;
  logic [1:0]    fill_q, fill_d;
  logic          ovf_q, ovf_d;

  logic          ord_use;
  logic [DW-1:0] shifted;
  logic          push;
  logic          pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ord_q   <= 1'b0;
      ent0_q  <= '0;
      ent1_q  <= '0;
      fill_q  <= 2'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ord_q   <= ord_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      fill_q  <= fill_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ord_d   = ord_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    fill_d  = fill_q;
    ovf_d   = ovf_q;
    push    = 1'b0;

    // The first bit of a word uses the live order input, which is latched for the rest.
    ord_use = (state_q == IDLE) ? msb_first : ord_q;
    shifted = ord_use ? {acc_q[DW-2:0], ser_in} : {ser_in, acc_q[DW-1:1]};

    if (enb) begin
      acc_d = shifted;
      case (state_q)
        IDLE: begin
          ord_d   = msb_first;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
        SHIFT: begin
          if (cnt_q == CW'(DW - 1)) begin
            push    = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    pop = (fill_q != 2'd0) && out_ready;

    // Entry 0 is always the head and is kept zero while the FIFO is empty.
    case (fill_q)
      2'd0: begin
        if (push) begin
          ent0_d = shifted;
          fill_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          ent0_d = shifted;
        end else if (pop) begin
          ent0_d = '0;
          fill_d = 2'd0;
        end else if (push) begin
          ent1_d = shifted;
          fill_d = 2'd2;
        end
      end
      default: begin
        if (pop) begin
          ent0_d = ent1_q;
          if (push) begin
            ent1_d = shifted;
          end else begin
            ent1_d = '0;
            fill_d = 2'd1;
          end
        end else if (push) begin
          ovf_d = 1'b1;
        end
      end
    endcase

    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '0;
      ord_d   = 1'b0;
      ent0_d  = '0;
      ent1_d  = '0;
      fill_d  = 2'd0;
      ovf_d   = 1'b0;
    end
  end

  assign out_data  = ent0_q;
  assign out_valid = (fill_q != 2'd0);
  assign fill      = fill_q;
  assign bit_cnt   = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_word_rx.sv
// tb/tb_serial_word_rx.sv - directed bench for serial_word_rx with an expected-word scoreboard
module tb_serial_word_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic       ser_in;
  logic       msb_first;
  logic       clr;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic [1:0] fill;
  logic [1:0] bit_cnt;
  logic       overflow;

  int vectors = 0;
  int errors  = 0;
  logic [3:0] sb[$];

  serial_word_rx #(.DW(4)) dut (
    .clk(clk), .rst(rst), .enb(enb), .ser_in(ser_in), .msb_first(msb_first),
    .clr(clr), .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
    .fill(fill), .bit_cnt(bit_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bits are listed first-received first: seq[3] is sent first.
  function automatic logic [3:0] model_word(input logic [3:0] seq, input logic msb);
    logic [3:0] w;
    w = 4'h0;
    for (int i = 3; i >= 0; i--) w = msb ? {w[2:0], seq[i]} : {seq[i], w[3:1]};
    return w;
  endfunction

  task automatic send_bits(input logic [3:0] seq, input int nbits, input int first, input logic msb);
    msb_first = msb;
    for (int i = first; i < first + nbits; i++) begin
      enb    = 1'b1;
      ser_in = seq[3-i];
      tick();
    end
    enb = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] seq, input logic msb, input bit expect_kept);
    if (expect_kept) sb.push_back(model_word(seq, msb));
    send_bits(seq, 4, 0, msb);
  endtask

  task automatic expect_pop(input string tag);
    logic [3:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    chk({tag, "_valid"}, 8'(out_valid), 8'd1);
    exp = (sb.size() > 0) ? sb.pop_front() : 4'hx;
    chk({tag, "_data"}, 8'(out_data), 8'(exp));
    tick();
  endtask

  initial begin
    rst = 1'b0; enb = 1'b0; ser_in = 1'b0; msb_first = 1'b1; clr = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_data", 8'(out_data), 8'h0);
    chk("rst_valid", 8'(out_valid), 8'h0);
    chk("rst_fill", 8'(fill), 8'h0);
    chk("rst_bitcnt", 8'(bit_cnt), 8'h0);
    chk("rst_ovf", 8'(overflow), 8'h0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Asynchronous reset with one buffered word and a partial word
    send_word(4'h9, 1'b1, 1'b0);
    send_bits(4'hF, 2, 0, 1'b1);
    chk("pre_rst_fill", 8'(fill), 8'd1);
    chk("pre_rst_bitcnt", 8'(bit_cnt), 8'd2);
    #3 rst = 1'b0;
    #1;
    chk("arst_data", 8'(out_data), 8'h0);
    chk("arst_valid", 8'(out_valid), 8'h0);
    chk("arst_fill", 8'(fill), 8'h0);
    chk("arst_bitcnt", 8'(bit_cnt), 8'h0);
    rst = 1'b1;
    tick();
    send_word(4'b1100, 1'b1, 1'b1);
    expect_pop("after_rst");

    // Bit order with out_ready held high: valid for exactly one cycle
    out_ready = 1'b1;
    send_word(4'b1011, 1'b1, 1'b1);
    chk("msb_valid", 8'(out_valid), 8'd1);
    chk("msb_data", 8'(out_data), 8'(sb.pop_front()));
    tick();
    chk("msb_valid_1cyc", 8'(out_valid), 8'd0);
    send_word(4'b1011, 1'b0, 1'b1);
    chk("lsb_data", 8'(out_data), 8'(sb.pop_front()));
    tick();
    sb.push_back(model_word(4'b1011, 1'b1));
    send_bits(4'b1011, 2, 0, 1'b1);
    send_bits(4'b1011, 2, 2, 1'b0);
    chk("toggle_data", 8'(out_data), 8'(sb.pop_front()));
    tick();

    // Gapped strobes
    sb.push_back(model_word(4'b0110, 1'b1));
    for (int i = 0; i < 4; i++) begin
      send_bits(4'b0110, 1, i, 1'b1);
      chk("gap_bitcnt", 8'(bit_cnt), 8'((i + 1) % 4));
      if (i < 3) begin
        chk("gap_novalid", 8'(out_valid), 8'd0);
        tick(); tick(); tick();
      end
    end
    chk("gap_valid", 8'(out_valid), 8'd1);
    chk("gap_data", 8'(out_data), 8'(sb.pop_front()));
    tick();
    chk("gap_valid_1cyc", 8'(out_valid), 8'd0);

    // Backpressure and overflow
    out_ready = 1'b0;
    send_word(4'h1, 1'b1, 1'b1);
    send_word(4'h2, 1'b1, 1'b1);
    send_word(4'h3, 1'b1, 1'b0);
    chk("bp_fill", 8'(fill), 8'd2);
    chk("bp_ovf", 8'(overflow), 8'd1);
    expect_pop("bp_pop1");
    expect_pop("bp_pop2");
    chk("bp_empty", 8'(out_valid), 8'd0);
    chk("bp_ovf_sticky", 8'(overflow), 8'd1);
    out_ready = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("bp_ovf_clr", 8'(overflow), 8'd0);

    // Push into a full buffer on the same cycle as a pop
    send_word(4'hA, 1'b1, 1'b1);
    send_word(4'h5, 1'b1, 1'b1);
    send_word(4'h7, 1'b1, 1'b1);
    chk("sim_ovf_pre", 8'(overflow), 8'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    sb.delete();
    send_word(4'hA, 1'b1, 1'b1);
    send_word(4'h5, 1'b1, 1'b1);
    sb.push_back(model_word(4'h7, 1'b1));
    send_bits(4'h7, 3, 0, 1'b1);
    chk("sim_head", 8'(out_data), 8'(sb.pop_front()));
    out_ready = 1'b1;
    send_bits(4'h7, 1, 3, 1'b1);
    out_ready = 1'b0;
    chk("sim_ovf", 8'(overflow), 8'd0);
    chk("sim_fill", 8'(fill), 8'd2);
    expect_pop("sim_pop1");
    expect_pop("sim_pop2");

    // clr with a full buffer, overflow set, a partial word and a strobe/pop in the same cycle
    out_ready = 1'b0;
    send_word(4'h1, 1'b1, 1'b0);
    send_word(4'h2, 1'b1, 1'b0);
    send_word(4'h3, 1'b1, 1'b0);
    send_bits(4'hF, 2, 0, 1'b1);
    clr = 1'b1; enb = 1'b1; ser_in = 1'b1; out_ready = 1'b1;
    tick();
    clr = 1'b0; enb = 1'b0; out_ready = 1'b0;
    chk("clr_bitcnt", 8'(bit_cnt), 8'd0);
    chk("clr_fill", 8'(fill), 8'd0);
    chk("clr_valid", 8'(out_valid), 8'd0);
    chk("clr_ovf", 8'(overflow), 8'd0);
    chk("clr_data", 8'(out_data), 8'd0);
    send_word(4'b0111, 1'b0, 1'b1);
    expect_pop("clr_fresh");
    chk("sb_drained", 8'(sb.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
